// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
//   Shared types and constants for the FPU operand front end.
//   - binary32 field geometry and the extended mantissa layout
//     {hidden, frac[22:0], guard[3:0]} consumed by renormalize_round.
//   - state_t    : unpack/normalize FSM encoding (IDLE, NORM, DONE).
//   - fp_class_t : operand class flags produced by fp_classify.
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int FRAC_W   = 23;
    localparam int GUARD_W  = 4;
    localparam int MANT_W   = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic sub;
    } fp_class_t;

endpackage : fpu_pkg

// File: rtl/fp_classify.sv
// ----------------------------------------------------------------------------
// fp_classify
//   Combinational classifier for an IEEE-754 binary32 word.
//   Ports:
//     operand  in  32   binary32 word
//     cls      out  fp_class_t {zero, inf, nan, sub}; at most one bit set,
//                   all clear for a normal number.
// ----------------------------------------------------------------------------
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] operand,
    output fp_class_t   cls
);

    logic [7:0]        exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic              exp_all0;
    logic              exp_all1;
    logic              frac_zero;
    // The sign plays no part in the class.
    logic              unused_sign;

    assign exp_f       = operand[30:23];
    assign frac_f      = operand[22:0];
    assign unused_sign = operand[31];

    assign exp_all0  = (exp_f == 8'd0);
    assign exp_all1  = (exp_f == 8'(EXP_MAX));
    assign frac_zero = (frac_f == '0);

    always_comb begin
        cls      = '0;
        cls.zero = exp_all0 &  frac_zero;
        cls.sub  = exp_all0 & ~frac_zero;
        cls.inf  = exp_all1 &  frac_zero;
        cls.nan  = exp_all1 & ~frac_zero;
    end

endmodule : fp_classify

// File: rtl/fp_unpack_normalize.sv
// ----------------------------------------------------------------------------
// fp_unpack_normalize
//   Operand front end of the FPU datapath. Splits a binary32 word into sign,
//   signed biased exponent and a 28-bit extended mantissa
//   {hidden, frac[22:0], 4'b0}, flags zero/inf/NaN, and normalizes subnormals
//   iteratively (up to SHIFT_PER_CYC left shifts per NORM cycle, decrementing
//   the exponent by the same amount). One operand in flight.
//
//   Configuration macro: UNPACK_FTZ_EN
//     defined   : subnormal inputs flush to signed zero with o_un_fl=1 in one
//                 cycle; NORM is never entered.
//     undefined : full iterative normalization.
//
//   Handshake (both sides): a word moves on a rising clock edge where its
//   valid and the matching ready are both high. o_ready depends on i_ready
//   combinationally so a retiring result and a new operand can swap on the
//   same edge; once o_valid is high it and every data/flag output stay
//   constant until the edge where i_ready is high.
//
//   Ports:
//     i_clk, i_rst_n        clock, async active-low reset
//     i_valid, o_ready      operand handshake
//     i_operand [31:0]      binary32 operand
//     o_valid, i_ready      result handshake
//     o_sign                sign bit
//     o_exp [EXP_W-1:0]     signed biased exponent after normalization
//     o_mant [MANT_W-1:0]   extended mantissa
//     o_zero/o_inf/o_nan    class flags, mutually exclusive
//     o_un_fl               normalized exponent < 1 (input was subnormal)
//     o_state               FSM state, for observation
// ----------------------------------------------------------------------------
module fp_unpack_normalize
    import fpu_pkg::*;
#(
    parameter int SHIFT_PER_CYC = 1,   // 1, 2, 4 or 8
    parameter int EXP_W         = 10,
    parameter int MANT_W        = 28
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [31:0]             i_operand,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sign,
    output logic signed [EXP_W-1:0] o_exp,
    output logic [MANT_W-1:0]       o_mant,
    output logic                    o_zero,
    output logic                    o_inf,
    output logic                    o_nan,
    output logic                    o_un_fl,
    output state_t                  o_state
);

    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [MANT_W-1:0]       mant_q, mant_d;
    logic                    zero_q, zero_d;
    logic                    inf_q, inf_d;
    logic                    nan_q, nan_d;
    logic                    un_fl_q, un_fl_d;

    fp_class_t               cls;
    logic                    accept;
    logic [7:0]              op_exp;
    logic [FRAC_W-1:0]       op_frac;

    logic [3:0]              shamt;
    logic                    found_one;
    logic [MANT_W-1:0]       mant_sh;
    logic signed [EXP_W-1:0] exp_sh;

    fp_classify u_classify (
        .operand (i_operand),
        .cls     (cls)
    );

    assign op_exp  = i_operand[30:23];
    assign op_frac = i_operand[22:0];

    assign o_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_ready);
    assign accept  = i_valid & o_ready;

    // Shift amount for one NORM step: leading zeros of the top SHIFT_PER_CYC
    // mantissa bits, capped at SHIFT_PER_CYC. Stopping at the first one keeps
    // the leading one from being shifted out past the hidden position.
    always_comb begin
        shamt     = 4'(SHIFT_PER_CYC);
        found_one = 1'b0;
        for (int i = 0; i < SHIFT_PER_CYC; i++) begin
            if (!found_one && mant_q[MANT_W-1-i]) begin
                shamt     = 4'(i);
                found_one = 1'b1;
            end
        end
    end

    assign mant_sh = mant_q << shamt;
    assign exp_sh  = exp_q - $signed({{(EXP_W-4){1'b0}}, shamt});

    // Next-state and datapath load/update.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        un_fl_d = un_fl_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    sign_d  = i_operand[31];
                    zero_d  = 1'b0;
                    inf_d   = 1'b0;
                    nan_d   = 1'b0;
                    un_fl_d = 1'b0;
                    state_d = ST_DONE;
                    if (cls.zero) begin
                        zero_d = 1'b1;
                        exp_d  = '0;
                        mant_d = '0;
                    end else if (cls.inf) begin
                        inf_d  = 1'b1;
                        exp_d  = EXP_W'(EXP_MAX);
                        mant_d = '0;
                    end else if (cls.nan) begin
                        nan_d  = 1'b1;
                        exp_d  = EXP_W'(EXP_MAX);
                        mant_d = {1'b0, op_frac, {GUARD_W{1'b0}}};
                    end else if (cls.sub) begin
`ifdef UNPACK_FTZ_EN
                        zero_d  = 1'b1;
                        un_fl_d = 1'b1;
                        exp_d   = '0;
                        mant_d  = '0;
`else
                        // Subnormals carry the minimum normal exponent and no
                        // hidden bit; NORM slides the leading one up to bit 27.
                        exp_d   = EXP_ONE;
                        mant_d  = {1'b0, op_frac, {GUARD_W{1'b0}}};
                        state_d = ST_NORM;
`endif
                    end else begin
                        exp_d  = {{(EXP_W-8){1'b0}}, op_exp};
                        mant_d = {1'b1, op_frac, {GUARD_W{1'b0}}};
                    end
                end else if ((state_q == ST_DONE) && i_ready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_NORM: begin
                mant_d = mant_sh;
                exp_d  = exp_sh;
                if (mant_sh[MANT_W-1]) begin
                    state_d = ST_DONE;
                    un_fl_d = (exp_sh < EXP_ONE);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            un_fl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            un_fl_q <= un_fl_d;
        end
    end

    assign o_valid = (state_q == ST_DONE);
    assign o_sign  = sign_q;
    assign o_exp   = exp_q;
    assign o_mant  = mant_q;
    assign o_zero  = zero_q;
    assign o_inf   = inf_q;
    assign o_nan   = nan_q;
    assign o_un_fl = un_fl_q;
    assign o_state = state_q;

endmodule : fp_unpack_normalize

// File: tb/tb_fp_unpack_normalize.sv
// ----------------------------------------------------------------------------
// tb_fp_unpack_normalize
//   Self-checking bench for fp_unpack_normalize. Expected results come from a
//   reference model that decodes binary32 arithmetically (leading-one search,
//   exponent = 1 - leading zeros) and predicts latency from the shift rate.
//   Honors UNPACK_FTZ_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_fp_unpack_normalize;
    import fpu_pkg::*;

    localparam int SHIFT = 1;
    localparam int EW    = 10;
    localparam int RW    = 1 + EW + 28 + 4;   // {sign, exp, mant, zero, inf, nan, un_fl}

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_operand;
    logic          o_valid;
    logic          i_ready;
    logic          o_sign;
    logic signed [EW-1:0] o_exp;
    logic [27:0]   o_mant;
    logic          o_zero, o_inf, o_nan, o_un_fl;
    state_t        o_state;

    always #5 clk = ~clk;

    fp_unpack_normalize #(.SHIFT_PER_CYC(SHIFT), .EXP_W(EW), .MANT_W(28)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_operand (i_operand),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sign    (o_sign),
        .o_exp     (o_exp),
        .o_mant    (o_mant),
        .o_zero    (o_zero),
        .o_inf     (o_inf),
        .o_nan     (o_nan),
        .o_un_fl   (o_un_fl),
        .o_state   (o_state)
    );

    // ---------------- check / counters ----------------
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model(input logic [31:0] op, output int lat);
        int          e, f, p, lz, ex;
        logic [27:0] m;
        logic        z, inf, nan, un;
        e = int'(op[30:23]);
        f = int'(op[22:0]);
        z = 0; inf = 0; nan = 0; un = 0; m = '0; ex = 0; lat = 1;
        if (e == 255) begin
            ex = 255;
            if (f == 0) inf = 1;
            else begin nan = 1; m = 28'(f) << 4; end
        end else if (e == 0 && f == 0) begin
            z = 1;
        end else if (e == 0) begin
`ifdef UNPACK_FTZ_EN
            z = 1; un = 1;
`else
            p = 0;
            for (int b = 0; b < 23; b++) if ((f >> b) & 1) p = b;
            lz  = 23 - p;
            ex  = 1 - lz;
            m   = 28'(f) << (4 + lz);
            un  = (ex < 1);
            lat = 1 + (lz + SHIFT - 1) / SHIFT;
`endif
        end else begin
            ex = e;
            m  = (28'(1) << 27) | (28'(f) << 4);
        end
        model = {op[31], 10'(ex), m, z, inf, nan, un};
    endfunction

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];
    int            acc_q[$];
    int            neg_cnt = 0;
    logic          held    = 0;
    logic [RW-1:0] stash;
    logic [RW-1:0] cur;
    logic          exp_v, exp_r;
    int            lat_tmp;

    always @(negedge clk) begin
        neg_cnt++;
        cur = {o_sign, o_exp, o_mant, o_zero, o_inf, o_nan, o_un_fl};
        if (!rst_n) begin
            exp_q.delete(); lat_q.delete(); acc_q.delete();
            held = 0;
        end else begin
            exp_v = (exp_q.size() != 0) && ((neg_cnt - acc_q[0]) >= lat_q[0]);
            exp_r = (exp_q.size() == 0) || (o_valid && i_ready);
            check("valid", 64'(o_valid), 64'(exp_v));
            check("ready", 64'(o_ready), 64'(exp_r));
            if (held) check("hold", 64'(cur), 64'(stash));
            if (o_valid && i_ready && exp_q.size() != 0) begin
                check("result", 64'(cur), 64'(exp_q[0]));
                void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(acc_q.pop_front());
                held = 0;
            end else if (o_valid) begin
                stash = cur;
                held  = 1;
            end else begin
                held = 0;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_operand, lat_tmp));
                lat_q.push_back(lat_tmp);
                acc_q.push_back(neg_cnt);
            end
        end
    end

    // ---------------- drivers ----------------
    logic ready_rand = 0;

    initial forever begin
        @(posedge clk); #1;
        if (ready_rand) i_ready = ($urandom_range(0, 3) != 0);
    end

    // Called and returning at posedge+1; returns just after the accept edge.
    task automatic send(input logic [31:0] op);
        int n;
        n = 0;
        i_valid   = 1'b1;
        i_operand = op;
        @(negedge clk);
        while (!o_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("send_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        i_valid   = 1'b0;
        i_operand = $urandom;
    endtask

    task automatic directed(input logic [31:0] op, input logic ws, input int we,
                            input logic [27:0] wm, input logic [3:0] wf, input int wl);
        int         n;
        logic [9:0] ge, wex;
        ready_rand = 0;
        i_ready    = 1'b1;
        send(op);
        n = 1;
        @(negedge clk);
        while (!o_valid && n < 100) begin @(negedge clk); n++; end
        ge  = o_exp;
        wex = 10'(we);
        check("dir_latency", 64'(n), 64'(wl));
        check("dir_sign", 64'(o_sign), 64'(ws));
        check("dir_exp", 64'(ge), 64'(wex));
        check("dir_mant", 64'(o_mant), 64'(wm));
        check("dir_flags", 64'({o_zero, o_inf, o_nan, o_un_fl}), 64'(wf));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_op();
        int          cat, p;
        logic [7:0]  e;
        logic [22:0] f;
        cat = $urandom_range(0, 9);
        e = 8'($urandom_range(1, 254));
        f = 23'($urandom);
        if (cat >= 4 && cat <= 6) begin
            p = $urandom_range(0, 22);
            e = 8'd0;
            f = (23'($urandom) & ((23'(1) << p) - 23'(1))) | (23'(1) << p);
        end else if (cat == 7) begin
            e = 8'd0;   f = '0;
        end else if (cat == 8) begin
            e = 8'hFF;  f = '0;
        end else if (cat == 9) begin
            e = 8'hFF;  f = 23'($urandom_range(1, 23'h7FFFFF));
        end
        rand_op = {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
        #1;
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_operand = '0;
        #23;
        check("rst_outputs", 64'({o_valid, o_sign, o_exp, o_mant, o_zero, o_inf, o_nan, o_un_fl}), 64'(0));
        check("rst_state", 64'(o_state), 64'(ST_IDLE));
        @(negedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 64'(o_ready), 64'(1));

        // Directed vectors (flags = {zero, inf, nan, un_fl})
        directed(32'h3F800000, 1'b0, 127, 28'h8000000, 4'b0000, 1);
`ifdef UNPACK_FTZ_EN
        directed(32'h00400000, 1'b0, 0, 28'h0, 4'b1001, 1);
        directed(32'h80000001, 1'b1, 0, 28'h0, 4'b1001, 1);
        directed(32'h00000001, 1'b0, 0, 28'h0, 4'b1001, 1);
`else
        directed(32'h00400000, 1'b0, 0, 28'h8000000, 4'b0001, 1 + (1 + SHIFT - 1) / SHIFT);
        directed(32'h80000001, 1'b1, -22, 28'h8000000, 4'b0001, 1 + (23 + SHIFT - 1) / SHIFT);
`endif
        directed(32'h7F800000, 1'b0, 255, 28'h0, 4'b0100, 1);
        directed(32'h7FC00000, 1'b0, 255, 28'h4000000, 4'b0010, 1);
        directed(32'h80000000, 1'b1, 0, 28'h0, 4'b1000, 1);

        // Backpressure, then back-to-back accept on the retiring edge
        i_ready = 1'b0;
        send(32'h40490FDB);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(o_valid), 64'(1));
            check("bp_ready", 64'(o_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        i_operand = 32'h3F800000;
        @(negedge clk);
        check("b2b_ready", 64'(o_ready), 64'(1));
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_bubble", 64'(o_valid), 64'(1));
        check("b2b_exp", 64'(o_mant), 64'(28'h8000000));
        @(posedge clk); #1;
        drain();

`ifndef UNPACK_FTZ_EN
        // Reset in the middle of normalization discards the operand
        i_ready = 1'b1;
        send(32'h00000001);
        repeat (3) @(posedge clk);
        #1;
        check("mid_norm_state", 64'(o_state), 64'(ST_NORM));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        check("mid_rst_state", 64'(o_state), 64'(ST_IDLE));
        @(negedge clk);
        @(negedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(o_ready), 64'(1));
        check("post_rst_valid", 64'(o_valid), 64'(0));
        repeat (30) @(posedge clk);
        #1;
`endif

        // Randomized traffic with random downstream backpressure
        ready_rand = 1;
        for (int k = 0; k < 300; k++) begin
            send(rand_op());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_rand = 0;
        i_ready    = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fp_unpack_normalize
